float_add_scheduler: RTL and testbench
======================================

Name: float_add_scheduler

Overview:
- Arbitrates two requesters onto one shared multi-cycle single-precision float adder. The adder uses a start/done handshake.
- Round-robin grant, one operation in flight.
- Latches the operands, drives the adder, times out a hung adder, and returns a tagged result to the winning requester.
- Sits between the client blocks and the float adder datapath.

Parameters:
- TIMEOUT, 64, max cycles in WAIT before aborting the op; legal range 2..65535.
- CNT_W, 16, width of the completion counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; combinational, at most one bit high.
- req_a  in  64  operand A; bits [32i+31:32i] belong to requester i.
- req_b  in  64  operand B, same packing as req_a.
- add_start  out  1  one-cycle start pulse to the adder.
- add_a  out  32  operand A to the adder; stable from ISSUE through the end of WAIT.
- add_b  out  32  operand B to the adder, same timing as add_a.
- add_done  in  1  adder result-valid pulse.
- add_sum  in  32  adder result; valid when add_done=1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester index the response belongs to.
- rsp_sum  out  32  result.
- rsp_err  out  1  1 = timeout abort.
- busy  out  1  high in every state except IDLE.
- done_cnt  out  CNT_W  count of completed responses; wraps.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; last_grant=1, so requester 0 wins first. All outputs 0: add_a, add_b, rsp_sum, rsp_id, rsp_err, done_cnt, req_ready.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant selection:
  - Only one req_valid bit set: grant that requester.
  - Both set: grant the index != last_grant.
  - req_ready[g]=1 combinationally for the granted requester only.
  - On valid&ready: latch A/B of g into add_a/add_b, store g; next state ISSUE.
  - No request: stay in IDLE.
- ISSUE: add_start=1 for exactly this cycle; timer cleared to 0; next state WAIT.
- WAIT:
  - Timer increments each cycle.
  - add_done=1: capture add_sum into rsp_sum, rsp_err=0; next state RESP.
  - Else, timer == TIMEOUT-1: rsp_sum=32'h7FC00000 (quiet NaN), rsp_err=1; next state RESP.
  - If add_done=1 coincides with the timeout cycle, done wins (rsp_err=0).
- add_done outside WAIT (including during ISSUE) is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_sum and rsp_err are held stable until rsp_ready.
  - On rsp_valid&rsp_ready: last_grant=g; done_cnt+1 (wraps to 0 at max); next state IDLE.
  - req_ready=0 throughout RESP.
- Latency: request accept to rsp_valid = 2 + adder latency cycles, minimum 3 (done on first WAIT cycle). Minimum back-to-back issue interval is 4 cycles.
- Requesters must hold req_valid and operands until accepted. Deasserting req_valid before accept drops the request without side effects.
- Reset mid-operation: the in-flight op is discarded, no response is produced, and the state returns to IDLE. A late add_done is later ignored.
- The block performs no float arithmetic; sums pass through bit-exact.

Test Plan:
1. Req0 only, A=3F800000 (1.0), B=40000000 (2.0); adder model done after 3 cycles with 40400000 -> rsp_valid with rsp_id=0, rsp_sum=40400000, rsp_err=0; done_cnt=1; add_start high exactly 1 cycle.
2. Both requesters valid continuously: req0 (1.0+1.0), req1 (40400000+3F800000) -> grants alternate 0,1,0,1; responses 40000000 / 40800000 carry matching rsp_id; no requester is granted twice in a row.
3. Adder never asserts done, TIMEOUT=64 -> rsp_valid exactly 66 cycles after accept, with rsp_sum=7FC00000 and rsp_err=1; the next request is then served normally.
4. Hold rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, req_ready stays 0, no new add_start; release -> return to IDLE.
5. Assert rst_n=0 mid-WAIT, then inject a stray add_done after release -> outputs are 0 and no response appears; the next req0 (C0A00000 + 40A00000, done with 00000000) returns 00000000.
6. Run 65536 completions with CNT_W=16 -> done_cnt wraps to 0; add_done pulsed during ISSUE is ignored.

Source files
------------

// File: rtl/float_add_scheduler.sv
// float_add_scheduler: round-robin arbiter sharing one start/done float adder between two requesters,
// with a WAIT-state timeout that returns a quiet NaN tagged as an error.
module float_add_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    output logic             add_start,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic             add_done,
    input  logic [31:0]      add_sum,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_sum,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;
    state_t           state_q, state_d;
    logic             last_q, last_d, gid_q, gid_d, err_q, err_d, g;
    logic [31:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [15:0]      tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // With both requesting, the one not served last wins.
    assign g = (&req_valid) ? ~last_q : req_valid[1];
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gid_d     = gid_q;
        err_d     = err_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        tmr_d     = tmr_q;
        cnt_d     = cnt_q;
        req_ready = 2'b00;
        add_start = 1'b0;
        case (state_q)
            IDLE: if (|req_valid) begin
                req_ready = g ? 2'b10 : 2'b01;
                a_d       = g ? req_a[63:32] : req_a[31:0];
                b_d       = g ? req_b[63:32] : req_b[31:0];
                gid_d     = g;
                state_d   = ISSUE;
            end
            ISSUE: begin
                add_start = 1'b1;
                tmr_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                tmr_d = tmr_q + 16'd1;
                if (add_done) begin
                    sum_d   = add_sum;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmr_q == T_LAST) begin
                    sum_d   = QNAN;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: if (rsp_ready) begin
                last_d  = gid_q;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gid_q   <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
        end
    end
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = gid_q;
    assign rsp_sum   = sum_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt  = cnt_q;
endmodule

// File: tb/tb_float_add_scheduler.sv
// tb_float_add_scheduler: randomized transactions against a round-robin/timeout reference model,
// with the adder emulated by a programmable-latency done pulse.
module tb_float_add_scheduler;
    localparam int TO = 64;
    localparam int CW = 8;
    logic          clk = 1'b0, rst_n = 1'b0;
    logic [1:0]    req_valid = '0, req_ready;
    logic [63:0]   req_a = '0, req_b = '0;
    logic          add_start, add_done = 1'b0, rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err, busy;
    logic [31:0]   add_a, add_b, add_sum = '0, rsp_sum;
    logic [CW-1:0] done_cnt;
    int            n_vec = 0, n_err = 0, exp_cnt = 0;
    logic          last_g = 1'b1;

    float_add_scheduler #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_done(add_done), .add_sum(add_sum), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err), .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction. lat = cycles from add_start to add_done (> TO means the adder hangs).
    task automatic run_op(input logic [1:0] v, input logic [63:0] a, input logic [63:0] b,
                          input int lat, input logic [63:0] s, input int hold, input logic stray);
        logic        g, ee;
        logic [31:0] ea, eb, es;
        int          el, k;
        g  = (v == 2'b11) ? ~last_g : v[1];
        ea = g ? a[63:32] : a[31:0];
        eb = g ? b[63:32] : b[31:0];
        ee = (lat > TO);
        el = ee ? TO : lat;
        es = ee ? 32'h7FC0_0000 : (g ? s[63:32] : s[31:0]);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        #1;
        chk("req_ready_grant", 32'(req_ready), g ? 32'd2 : 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        chk("add_start_issue", 32'(add_start), 32'd1);
        chk("add_a", add_a, ea);
        chk("add_b", add_b, eb);
        chk("req_ready_issue", 32'(req_ready), 32'd0);
        if (stray) begin
            add_done = 1'b1;
            add_sum  = 32'hDEAD_BEEF;
        end
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            add_done = 1'b0;
            if (rsp_valid) break;
            if (add_start !== 1'b0 || add_a !== ea || add_b !== eb)
                chk("wait_stable", {add_start, add_a[30:0]}, {1'b0, ea[30:0]});
            add_done = (k == lat);
            add_sum  = es;
        end
        chk("latency", 32'(k + 1), 32'(el + 2));
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_sum", rsp_sum, es);
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        for (int h = 0; h < hold; h++) begin
            req_valid = 2'b11;
            #1;
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_sum", rsp_sum, es);
            chk("hold_start", 32'(add_start), 32'd0);
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        last_g    = g;
        exp_cnt   = (exp_cnt + 1) % (1 << CW);
        chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_cnt", 32'(done_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r, lat;
        logic [1:0] v;
        #1;
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_rsp_sum", rsp_sum, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b01, {32'h0, 32'h3F80_0000}, {32'h0, 32'h4000_0000}, 3, {32'h0, 32'h4040_0000}, 0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_op(2'b11, {32'h4040_0000, 32'h3F80_0000}, {32'h3F80_0000, 32'h3F80_0000},
                   int'($urandom_range(1, 5)), {32'h4080_0000, 32'h4000_0000}, 0, 1'b0);
        run_op(2'b10, {$urandom, $urandom}, {$urandom, $urandom}, 1000, 64'h0, 0, 1'b0);
        run_op(2'b10, {$urandom, $urandom}, {$urandom, $urandom}, 2, {$urandom, $urandom}, 0, 1'b0);
        run_op(2'b01, {$urandom, $urandom}, {$urandom, $urandom}, 1, {$urandom, $urandom}, 10, 1'b0);
        req_valid = 2'b01;
        req_a     = {32'h0, 32'h1111_1111};
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_add_a", add_a, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_done_cnt", 32'(done_cnt), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_g   = 1'b1;
        exp_cnt  = 0;
        add_done = 1'b1;
        add_sum  = 32'h1234_5678;
        @(negedge clk);
        add_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("stray_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        run_op(2'b01, {32'h0, 32'hC0A0_0000}, {32'h0, 32'h40A0_0000}, 2, 64'h0, 0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            r   = int'($urandom_range(0, 29));
            lat = (r == 0) ? 1000 : (r == 1) ? TO : int'($urandom_range(1, 5));
            v   = 2'($urandom_range(1, 3));
            run_op(v, {$urandom, $urandom}, {$urandom, $urandom}, lat, {$urandom, $urandom},
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
